if_prefetch_buffer: RTL and testbench

Parametrised instruction-fetch front end that replaces the single-address, combinational fetch of the current IF stage. It owns the fetch PC, issues sequential word requests to instruction memory over a valid/ready request channel, accepts in-order responses, and buffers up to DEPTH fetched instructions, each tagged with its PC, for decode. A redirect from a branch, jump or trap flushes the buffer and re-steers fetch. Responses to requests issued before the redirect are discarded as they return.

---
 rtl/if_prefetch_buffer_if.sv | 44 ++++
 rtl/if_prefetch_buffer.sv | 133 +++++++++++++
 tb/tb_if_prefetch_buffer.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_prefetch_buffer_if.sv
// ---------------------------------------------------------------------------
// if_prefetch_buffer_if
//   Groups the signals of the instruction-fetch front end into one bundle:
//   the memory request channel, the in-order response channel, the redirect
//   input from the back end, and the instruction channel to decode.
//
//   master : the prefetch buffer (drives req_*, inst*, proto_err)
//   slave  : the environment (memory, decode and redirect source)
//
//   req_valid/req_ready/req_addr  word request to instruction memory
//   resp_valid/resp_data          in-order instruction return, always accepted
//   redirect_valid/redirect_pc    flush and re-steer fetch
//   inst_valid/inst_ready         buffer head handshake to decode
//   inst/inst_pc                  head instruction and its PC
//   proto_err                     sticky: response seen with nothing in flight
// ---------------------------------------------------------------------------
interface if_prefetch_buffer_if #(
  parameter int unsigned XLEN = 64
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            resp_valid;
  logic [31:0]     resp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic            proto_err;

  modport master (
    output req_valid, req_addr, inst_valid, inst, inst_pc, proto_err,
    input  req_ready, resp_valid, resp_data, redirect_valid, redirect_pc,
           inst_ready
  );

  modport slave (
    input  req_valid, req_addr, inst_valid, inst, inst_pc, proto_err,
    output req_ready, resp_valid, resp_data, redirect_valid, redirect_pc,
           inst_ready
  );
endinterface

// File: rtl/if_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// if_prefetch_buffer
//   Instruction-fetch front end. Owns the fetch PC, issues sequential word
//   requests to instruction memory, accepts in-order responses and buffers up
//   to DEPTH {pc, inst} entries for decode. A redirect flushes the buffer,
//   re-steers fetch and marks every still-outstanding response for discard.
//
//   Parameters : XLEN (PC width), RESET_PC (first fetch address),
//                DEPTH (buffer entries, power of two >= 2; also the cap on
//                in-flight requests plus buffered entries)
//   clk        : rising-edge clock
//   rst        : synchronous, active-high reset
//   bus        : if_prefetch_buffer_if.master (request, response, redirect,
//                decode channel and proto_err)
// ---------------------------------------------------------------------------
module if_prefetch_buffer #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 'h8000_0000,
  parameter int unsigned     DEPTH    = 4
) (
  input logic                  clk,
  input logic                  rst,
  if_prefetch_buffer_if.master bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [AW-1:0] ptr_t;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  cnt_t            inflight;
  cnt_t            drop;
  cnt_t            count;
  ptr_t            rd_ptr;
  ptr_t            wr_ptr;
  logic            proto_err_q;

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [31:0]     inst_mem [DEPTH];

  logic            redirect;
  logic [XLEN-1:0] redirect_pc_al;
  logic            credit;
  logic            req_fire;
  logic            resp_ok;
  logic            push;
  logic            pop;
  logic            fifo_nonempty;

  assign redirect       = bus.redirect_valid;
  assign redirect_pc_al = bus.redirect_pc & ~XLEN'(3);

  // Requests in flight plus buffered entries never exceed DEPTH, so every
  // kept response is guaranteed a free slot when it arrives.
  assign credit   = ({1'b0, inflight} + {1'b0, count}) < (CW+1)'(DEPTH);

  assign bus.req_valid = !rst && !redirect && credit;
  assign bus.req_addr  = fetch_pc;
  assign req_fire      = bus.req_valid && bus.req_ready;

  // A response with nothing in flight is a protocol error and is ignored.
  assign resp_ok = bus.resp_valid && (inflight != '0);
  assign push    = resp_ok && (drop == '0) && !redirect;

  assign fifo_nonempty  = (count != '0);
  assign bus.inst_valid = fifo_nonempty && !redirect;
  assign pop            = bus.inst_valid && bus.inst_ready;

  // Head is forced to zero when empty so outputs read 0 out of reset.
  assign bus.inst      = fifo_nonempty ? inst_mem[rd_ptr] : '0;
  assign bus.inst_pc   = fifo_nonempty ? pc_mem[rd_ptr]   : '0;
  assign bus.proto_err = proto_err_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      inflight    <= '0;
      drop        <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      // req_fire is already low during a redirect, so this holds either way.
      inflight <= inflight + cnt_t'(req_fire) - cnt_t'(resp_ok);

      if (bus.resp_valid && (inflight == '0)) begin
        proto_err_q <= 1'b1;
      end

      if (redirect) begin
        fetch_pc <= redirect_pc_al;
        resp_pc  <= redirect_pc_al;
        // Everything still outstanding after this cycle's response is stale.
        drop     <= inflight - cnt_t'(resp_ok);
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + XLEN'(4);
        end
        if (resp_ok && (drop != '0)) begin
          drop <= drop - cnt_t'(1);
        end
        if (push) begin
          wr_ptr  <= wr_ptr + ptr_t'(1);
          resp_pc <= resp_pc + XLEN'(4);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + ptr_t'(1);
        end
        count <= count + cnt_t'(push) - cnt_t'(pop);
      end
    end
  end

  // NOTE: buffer storage is not reset; count gates every read, so stale
  // contents are never visible and the array can map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= resp_pc;
      inst_mem[wr_ptr] <= bus.resp_data;
    end
  end

endmodule

// File: tb/tb_if_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// tb_if_prefetch_buffer
//   Directed bench for if_prefetch_buffer (DEPTH = 4). A small memory model
//   answers accepted requests one cycle later; the stimulus pushes the
//   expected {pc, inst} stream into a scoreboard queue and a separate monitor
//   compares every instruction decode accepts. Inputs change 1-2 time units
//   after the rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_if_prefetch_buffer;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic clk;
  logic rst;

  if_prefetch_buffer_if #(.XLEN(64)) bus ();

  if_prefetch_buffer #(
    .XLEN    (64),
    .RESET_PC(RST_PC),
    .DEPTH   (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  logic [63:0] pend_q[$];
  int          req_cnt = 0;
  logic [63:0] last_req_addr = '0;
  logic        mem_go = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // Instruction memory contents: a recognisable word per address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input logic [63:0] pc);
    exp_q.push_back('{pc: pc, inst: mem_word(pc)});
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic quiesce();
    bus.req_ready  = 1'b0;
    bus.inst_ready = 1'b0;
    mem_go         = 1'b1;
    repeat (6) tick();
  endtask

  task automatic redirect_to(input logic [63:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    tick();
    bus.redirect_valid = 1'b0;
  endtask

  // Request acceptance: record what memory owes us.
  always @(negedge clk) begin
    if (bus.req_valid && bus.req_ready) begin
      pend_q.push_back(bus.req_addr);
      req_cnt++;
      last_req_addr = bus.req_addr;
    end
  end

  // Memory model: one in-order response per cycle while mem_go is high.
  initial begin
    bus.resp_valid = 1'b0;
    bus.resp_data  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_go && pend_q.size() > 0) begin
        bus.resp_valid = 1'b1;
        bus.resp_data  = mem_word(pend_q.pop_front());
      end else begin
        bus.resp_valid = 1'b0;
        bus.resp_data  = '0;
      end
    end
  end

  // Scoreboard monitor: compare every instruction handed to decode.
  always @(negedge clk) begin
    if (bus.inst_valid && bus.inst_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_inst: got pc %h inst %h, required no instruction",
                 bus.inst_pc, bus.inst);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("inst_pc", bus.inst_pc, e.pc);
        check("inst", 64'(bus.inst), 64'(e.inst));
      end
    end
  end

  initial begin
    int rc0;

    rst                = 1'b1;
    bus.req_ready      = 1'b0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    repeat (3) tick();

    // Reset state
    @(negedge clk);
    check("rst_req_valid", 64'(bus.req_valid), 64'd0);
    check("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
    check("rst_inst", 64'(bus.inst), 64'd0);
    check("rst_inst_pc", bus.inst_pc, 64'd0);
    check("rst_proto_err", 64'(bus.proto_err), 64'd0);

    // Straight-line fetch
    for (int i = 0; i < 8; i++) exp_push(RST_PC + 64'(4 * i));
    tick();
    rst            = 1'b0;
    bus.req_ready  = 1'b1;
    bus.inst_ready = 1'b1;
    @(negedge clk);
    check("first_req_valid", 64'(bus.req_valid), 64'd1);
    check("first_req_addr", bus.req_addr, 64'h8000_0000);
    check("lat_c0_inst_valid", 64'(bus.inst_valid), 64'd0);
    @(negedge clk);
    check("lat_c1_inst_valid", 64'(bus.inst_valid), 64'd0);
    @(negedge clk);
    check("lat_c2_inst_valid", 64'(bus.inst_valid), 64'd1);
    wait_drain("drain_straight");
    quiesce();

    // Backpressure: four requests fill the buffer, one pop frees one slot
    redirect_to(64'h8000_0000);
    rc0            = req_cnt;
    bus.req_ready  = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    check("bp_req_count", 64'(req_cnt - rc0), 64'd4);
    check("bp_req_valid_full", 64'(bus.req_valid), 64'd0);
    check("bp_head_pc", bus.inst_pc, 64'h8000_0000);
    exp_push(64'h8000_0000);
    tick();
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    check("bp_req_count_after_pop", 64'(req_cnt - rc0), 64'd5);
    check("bp_refill_addr", last_req_addr, 64'h8000_0010);
    check("bp_req_valid_refull", 64'(bus.req_valid), 64'd0);
    wait_drain("drain_bp");
    quiesce();

    // Redirect with three in flight and one buffered
    redirect_to(64'h8000_0000);
    mem_go        = 1'b0;
    bus.req_ready = 1'b1;
    repeat (4) tick();
    bus.req_ready = 1'b0;
    mem_go        = 1'b1;
    tick();
    mem_go = 1'b0;
    tick();
    @(negedge clk);
    check("rd3_buffered_pc", bus.inst_pc, 64'h8000_0000);
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_0103;
    bus.req_ready      = 1'b1;
    @(negedge clk);
    check("rd3_no_req_in_redirect", 64'(bus.req_valid), 64'd0);
    check("rd3_no_inst_in_redirect", 64'(bus.inst_valid), 64'd0);
    tick();
    bus.redirect_valid = 1'b0;
    bus.inst_ready     = 1'b1;
    mem_go             = 1'b1;
    for (int i = 0; i < 4; i++) exp_push(64'h8000_0100 + 64'(4 * i));
    @(negedge clk);
    check("rd3_req_valid", 64'(bus.req_valid), 64'd1);
    check("rd3_req_addr_aligned", bus.req_addr, 64'h8000_0100);
    check("rd3_fifo_flushed", 64'(bus.inst_valid), 64'd0);
    wait_drain("drain_rd3");
    quiesce();

    // Redirect in the same cycle as a response, two in flight
    redirect_to(64'h8000_0200);
    mem_go        = 1'b0;
    bus.req_ready = 1'b1;
    tick();
    tick();
    bus.req_ready      = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_0300;
    mem_go             = 1'b1;
    @(negedge clk);
    check("rdr_inst_valid_in_redirect", 64'(bus.inst_valid), 64'd0);
    check("rdr_req_valid_in_redirect", 64'(bus.req_valid), 64'd0);
    tick();
    bus.redirect_valid = 1'b0;
    bus.req_ready      = 1'b1;
    bus.inst_ready     = 1'b1;
    for (int i = 0; i < 3; i++) exp_push(64'h8000_0300 + 64'(4 * i));
    @(negedge clk);
    check("rdr_req_addr", bus.req_addr, 64'h8000_0300);
    wait_drain("drain_rdr");
    quiesce();

    // Simultaneous push and pop at count = 2
    redirect_to(64'h8000_0400);
    mem_go        = 1'b0;
    bus.req_ready = 1'b1;
    repeat (3) tick();
    bus.req_ready = 1'b0;
    mem_go        = 1'b1;
    tick();
    tick();
    mem_go = 1'b0;
    @(negedge clk);
    check("pp_head_before", bus.inst_pc, 64'h8000_0400);
    for (int i = 0; i < 5; i++) exp_push(64'h8000_0400 + 64'(4 * i));
    tick();
    mem_go         = 1'b1;
    bus.inst_ready = 1'b1;
    tick();
    mem_go         = 1'b0;
    bus.inst_ready = 1'b0;
    @(negedge clk);
    check("pp_head_after", bus.inst_pc, 64'h8000_0404);
    rc0           = req_cnt;
    bus.req_ready = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    check("pp_credit_count2", 64'(req_cnt - rc0), 64'd2);
    tick();
    bus.req_ready  = 1'b0;
    bus.inst_ready = 1'b1;
    mem_go         = 1'b1;
    wait_drain("drain_pp");
    quiesce();

    // Reset mid-stream, then a stale response raises proto_err
    redirect_to(64'h8000_0500);
    mem_go        = 1'b0;
    bus.req_ready = 1'b1;
    repeat (3) tick();
    bus.req_ready = 1'b0;
    mem_go        = 1'b1;
    tick();
    tick();
    mem_go = 1'b0;
    @(negedge clk);
    check("mid_head_pc", bus.inst_pc, 64'h8000_0500);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("mid_req_valid_in_rst", 64'(bus.req_valid), 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_inst_valid", 64'(bus.inst_valid), 64'd0);
    check("mid_inst", 64'(bus.inst), 64'd0);
    check("mid_inst_pc", bus.inst_pc, 64'd0);
    check("mid_refetch_addr", bus.req_addr, RST_PC);
    check("mid_refetch_valid", 64'(bus.req_valid), 64'd1);
    check("mid_proto_err_clear", 64'(bus.proto_err), 64'd0);
    tick();
    mem_go = 1'b1;
    tick();
    mem_go = 1'b0;
    @(negedge clk);
    check("proto_err_set", 64'(bus.proto_err), 64'd1);
    check("proto_err_resp_ignored", 64'(bus.inst_valid), 64'd0);
    tick();
    for (int i = 0; i < 4; i++) exp_push(RST_PC + 64'(4 * i));
    bus.req_ready  = 1'b1;
    bus.inst_ready = 1'b1;
    mem_go         = 1'b1;
    wait_drain("drain_refetch");
    check("proto_err_sticky", 64'(bus.proto_err), 64'd1);
    quiesce();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("proto_err_cleared_by_rst", 64'(bus.proto_err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
